// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types for the i2c transaction arbiter:
// FSM states and the latched request bundle.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_DONE,
      ST_GAP,
      ST_REPORT
   } arb_state_t;

   typedef struct packed {
      logic                  rw;
      logic [I2C_ADDR_W-1:0] slave_addr;
      logic [I2C_DATA_W-1:0] reg_addr;
      logic [I2C_DATA_W-1:0] wdata;
   } i2c_req_t;

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot choice of the first request
// at or above ptr, pointer advances past the winner on stb.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 stb,
   output logic [N-1:0]         pick,
   output logic [$clog2(N)-1:0] pick_idx,
   output logic                 any
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr_q;
   int            idx;

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      any      = 1'b0;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!any && req[idx]) begin
            any       = 1'b1;
            pick[idx] = 1'b1;
            pick_idx  = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (stb && any) begin
         ptr_q <= (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master among N_REQ requesters with
// round-robin grant, watchdog abort and NACK retry.
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 200000,
   parameter int RETRY_MAX   = 2,
   parameter int GAP_CYC     = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ-1:0]              req_rw,
   input  logic [I2C_ADDR_W*N_REQ-1:0]   req_slave_addr,
   input  logic [I2C_DATA_W*N_REQ-1:0]   req_reg_addr,
   input  logic [I2C_DATA_W*N_REQ-1:0]   req_wdata,
   output logic [N_REQ-1:0]              gnt,
   output logic [N_REQ-1:0]              done,
   output logic [N_REQ-1:0]              err,
   output logic [I2C_DATA_W-1:0]         rdata,
   output logic                          m_start,
   output logic                          m_abort,
   output logic                          m_rw,
   output logic [I2C_ADDR_W-1:0]         m_slave_addr,
   output logic [I2C_DATA_W-1:0]         m_reg_addr,
   output logic [I2C_DATA_W-1:0]         m_wdata,
   input  logic                          m_busy,
   input  logic                          m_done,
   input  logic                          m_nack,
   input  logic [I2C_DATA_W-1:0]         m_rdata
);

   localparam int PW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam int GW = $clog2(GAP_CYC + 1);

   arb_state_t state_q, state_d;

   logic [N_REQ-1:0]      pick;
   logic [PW-1:0]         pick_idx;
   logic                  any;
   i2c_req_t              sel, fld_q;
   logic [N_REQ-1:0]      gnt_q;
   logic [TW-1:0]         timer_q;
   logic [RW-1:0]         retry_q;
   logic [GW-1:0]         gap_q;
   logic                  start_q, abort_q, rep_err_q;
   logic [I2C_DATA_W-1:0] rdata_q;

   logic grant, ok, fail, tout, retry, start_d;
   logic to_hit, retry_ok, gap_hit;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .stb      (grant),
      .pick     (pick),
      .pick_idx (pick_idx),
      .any      (any)
   );

   always_comb begin
      sel            = '0;
      sel.rw         = req_rw[pick_idx];
      sel.slave_addr = req_slave_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
      sel.reg_addr   = req_reg_addr[pick_idx*I2C_DATA_W +: I2C_DATA_W];
      sel.wdata      = req_wdata[pick_idx*I2C_DATA_W +: I2C_DATA_W];
   end

   assign to_hit   = (timer_q == TW'(TIMEOUT_CYC));
   assign retry_ok = (retry_q < RW'(RETRY_MAX));
   assign gap_hit  = (gap_q == GW'(GAP_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // m_done is checked before the watchdog so a late completion wins
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      ok      = 1'b0;
      fail    = 1'b0;
      tout    = 1'b0;
      retry   = 1'b0;
      start_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any) begin
               grant   = 1'b1;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (to_hit) begin
               tout    = 1'b1;
               state_d = ST_REPORT;
            end else if (m_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               start_d = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (m_done) begin
               if (!m_nack) begin
                  ok      = 1'b1;
                  state_d = ST_REPORT;
               end else if (retry_ok) begin
                  retry   = 1'b1;
                  state_d = ST_GAP;
               end else begin
                  fail    = 1'b1;
                  state_d = ST_REPORT;
               end
            end else if (to_hit) begin
               tout    = 1'b1;
               state_d = ST_REPORT;
            end
         end
         ST_GAP: begin
            if (gap_hit) state_d = ST_LAUNCH;
         end
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fld_q     <= '0;
         gnt_q     <= '0;
         timer_q   <= '0;
         retry_q   <= '0;
         gap_q     <= '0;
         start_q   <= 1'b0;
         abort_q   <= 1'b0;
         rep_err_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         start_q <= start_d;
         abort_q <= tout;
         if (state_q == ST_LAUNCH || state_q == ST_WAIT_DONE)
            timer_q <= timer_q + 1'b1;
         if (state_q == ST_GAP) begin
            gap_q   <= gap_q + 1'b1;
            timer_q <= '0;
         end
         if (grant) begin
            fld_q   <= sel;
            gnt_q   <= pick;
            timer_q <= '0;
            retry_q <= '0;
         end
         if (retry) begin
            retry_q <= retry_q + 1'b1;
            gap_q   <= '0;
         end
         if (ok) rdata_q <= m_rdata;
         if (ok || fail || tout) rep_err_q <= ~ok;
         if (state_q == ST_REPORT) gnt_q <= '0;
      end
   end

   assign gnt          = gnt_q;
   assign done         = (state_q == ST_REPORT && !rep_err_q) ? gnt_q : '0;
   assign err          = (state_q == ST_REPORT && rep_err_q) ? gnt_q : '0;
   assign rdata        = rdata_q;
   assign m_start      = start_q;
   assign m_abort      = abort_q;
   assign m_rw         = fld_q.rw;
   assign m_slave_addr = fld_q.slave_addr;
   assign m_reg_addr   = fld_q.reg_addr;
   assign m_wdata      = fld_q.wdata;

endmodule
